// File: rtl/vram_addr_sequencer.sv
// Video-RAM address sequencer: time-multiplexes the DRAM row/column address between
// video fetch (scroll counter + HL) and CPU access, and owns the vertical scroll counter.
module vram_addr_sequencer #(
    parameter int AW      = 8,
    parameter bit EXT_SEL = 1'b0
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              SEL_A,
    input  logic              SEL_B,
    input  logic              PH_EN,
    input  logic [2*AW-2:1]   DRBA,
    input  logic [AW-1:0]     HL,
    input  logic [AW-1:0]     BD,
    input  logic              PLAYER2,
    input  logic              HSYNCn,
    input  logic              VBLANK,
    input  logic              VSLDn,
    output logic [AW-1:0]     DRAB,
    output logic [1:0]        SLOT
);

    generate
        if (AW < 4) begin : g_aw_check
            $error("vram_addr_sequencer: AW must be >= 4");
        end
    endgenerate

    logic          hs_q;
    logic          hs_fall;
    logic [AW-1:0] y_q, y_d;
    logic [1:0]    ph_q, ph_d;
    logic [1:0]    sel;
    logic [AW-1:0] drab_q, drab_d;
    logic [1:0]    slot_q;

    // HSYNCn is sampled as data; a held low level yields a single pulse.
    assign hs_fall = hs_q & ~HSYNCn;

    // State registers
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            hs_q   <= 1'b1;
            y_q    <= '0;
            ph_q   <= 2'd0;
            drab_q <= '0;
            slot_q <= 2'd0;
        end else begin
            hs_q   <= HSYNCn;
            y_q    <= y_d;
            ph_q   <= ph_d;
            drab_q <= drab_d;
            slot_q <= sel;
        end
    end

    // Load wins over a coincident count; counting wraps naturally.
    always_comb begin
        y_d = y_q;
        if (!VSLDn)
            y_d = BD;
        else if (hs_fall && !VBLANK)
            y_d = PLAYER2 ? (y_q - 1'b1) : (y_q + 1'b1);
    end

    // Phase sequencer next state: line start realigns to the video-row slot.
    always_comb begin
        ph_d = ph_q;
        if (hs_fall)
            ph_d = 2'd0;
        else if (PH_EN)
            ph_d = ph_q + 2'd1;
    end

    // Output decode: slot select and address mux.
    always_comb begin
        sel = EXT_SEL ? {SEL_B, SEL_A} : ph_q;
        drab_d = '0;
        case (sel)
            2'd0:    drab_d = {1'b0, y_q[AW-1:2], 1'b0};
            2'd1:    drab_d = {y_q[1:0], HL[AW-1:2]};
            2'd2:    drab_d = {1'b0, DRBA[2*AW-2:AW+1], 1'b0};
            default: drab_d = DRBA[AW:1];
        endcase
    end

    assign DRAB = drab_q;
    assign SLOT = slot_q;

    // Inputs/state that are dead in one of the two select configurations.
    logic unused_sink;
    assign unused_sink = &{1'b0, HL[1:0], SEL_A, SEL_B, PH_EN, ph_q};

endmodule

// File: tb/tb_vram_addr_sequencer.sv
// Bench for vram_addr_sequencer: pin-select and phase-select instances driven in parallel,
// checked against a behavioural model plus directed scroll/mux/phase/reset sequences.
module tb_vram_addr_sequencer;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          RESETn, SEL_A, SEL_B, PH_EN, PLAYER2, HSYNCn, VBLANK, VSLDn;
    logic [14:1]   DRBA;
    logic [7:0]    HL, BD;
    logic [7:0]    drab_e, drab_i;
    logic [1:0]    slot_e, slot_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vram_addr_sequencer #(.AW(AW), .EXT_SEL(1'b1)) u_ext (
        .CLK(clk), .RESETn(RESETn), .SEL_A(SEL_A), .SEL_B(SEL_B), .PH_EN(PH_EN),
        .DRBA(DRBA), .HL(HL), .BD(BD), .PLAYER2(PLAYER2), .HSYNCn(HSYNCn),
        .VBLANK(VBLANK), .VSLDn(VSLDn), .DRAB(drab_e), .SLOT(slot_e));

    vram_addr_sequencer #(.AW(AW), .EXT_SEL(1'b0)) u_int (
        .CLK(clk), .RESETn(RESETn), .SEL_A(SEL_A), .SEL_B(SEL_B), .PH_EN(PH_EN),
        .DRBA(DRBA), .HL(HL), .BD(BD), .PLAYER2(PLAYER2), .HSYNCn(HSYNCn),
        .VBLANK(VBLANK), .VSLDn(VSLDn), .DRAB(drab_i), .SLOT(slot_i));

    // Reference model: DRBA carries byte-address bits [14:1], so address = DRBA*2.
    int         m_y, m_ph, m_de, m_se, m_di, m_si;
    bit         m_hs;

    function automatic int addr_of(int s, int y, int hl, int drba);
        int a;
        a = drba * 2;
        case (s)
            0:       return (y / 4) * 2;
            1:       return (y % 4) * 64 + hl / 4;
            2:       return ((a / 512) % 64) * 2;
            default: return (a / 2) % 256;
        endcase
    endfunction

    always @(posedge clk) begin
        bit fall;
        int se;
        if (!RESETn) begin
            m_y = 0; m_hs = 1; m_ph = 0;
            m_de = 0; m_se = 0; m_di = 0; m_si = 0;
        end else begin
            fall = m_hs && !HSYNCn;
            se   = {SEL_B, SEL_A};
            m_de = addr_of(se, m_y, HL, DRBA);
            m_se = se;
            m_di = addr_of(m_ph, m_y, HL, DRBA);
            m_si = m_ph;
            if (!VSLDn)
                m_y = BD;
            else if (fall && !VBLANK)
                m_y = PLAYER2 ? (m_y + 255) % 256 : (m_y + 1) % 256;
            if (fall)
                m_ph = 0;
            else if (PH_EN)
                m_ph = (m_ph + 1) % 4;
            m_hs = HSYNCn;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock; sample #1 after the edge and compare both instances to the model.
    task automatic step();
        @(posedge clk);
        #1;
        chk("drab_ext", drab_e, 8'(m_de));
        chk("slot_ext", {6'd0, slot_e}, 8'(m_se));
        chk("drab_int", drab_i, 8'(m_di));
        chk("slot_int", {6'd0, slot_i}, 8'(m_si));
    endtask

    task automatic idle();
        RESETn = 1'b1; HSYNCn = 1'b1; VSLDn = 1'b1; VBLANK = 1'b0;
        PLAYER2 = 1'b0; PH_EN = 1'b0;
    endtask

    // Y recovered from the pin-select instance's video row + column slots.
    task automatic read_y(output logic [7:0] y);
        logic [7:0] r;
        {SEL_B, SEL_A} = 2'd0; step(); r = drab_e;
        {SEL_B, SEL_A} = 2'd1; step();
        y = {r[6:1], drab_e[7:6]};
    endtask

    task automatic load_y(input logic [7:0] v);
        VSLDn = 1'b0; BD = v; step(); VSLDn = 1'b1;
    endtask

    task automatic hs_pulse();
        HSYNCn = 1'b0; step(); HSYNCn = 1'b1; step();
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [7:0] exp_drab;
    } vec_t;

    vec_t       tbl[4];
    logic [7:0] y;

    initial begin
        // Y=B7, HL=C8, byte address 2A5B -> DRBA = 152D
        tbl[0] = '{2'd0, 8'h5A};
        tbl[1] = '{2'd1, 8'hF2};
        tbl[2] = '{2'd2, 8'h2A};
        tbl[3] = '{2'd3, 8'h2D};

        // Reset with random inputs
        idle();
        RESETn = 1'b0;
        {SEL_B, SEL_A} = 2'($urandom); PH_EN = 1'($urandom); PLAYER2 = 1'($urandom);
        HSYNCn = 1'($urandom); VBLANK = 1'($urandom); VSLDn = 1'($urandom);
        DRBA = 14'($urandom); HL = 8'($urandom); BD = 8'($urandom);
        step();
        chk("rst_drab_ext", drab_e, 8'h00);
        chk("rst_slot_ext", {6'd0, slot_e}, 8'h00);
        chk("rst_drab_int", drab_i, 8'h00);
        chk("rst_slot_int", {6'd0, slot_i}, 8'h00);
        idle();
        read_y(y); chk("rst_y", y, 8'h00);

        // Load and count up through the wrap, then down through zero
        load_y(8'hFE); read_y(y); chk("load_fe", y, 8'hFE);
        hs_pulse(); read_y(y); chk("up_ff", y, 8'hFF);
        hs_pulse(); read_y(y); chk("up_wrap_00", y, 8'h00);
        hs_pulse(); read_y(y); chk("up_01", y, 8'h01);
        load_y(8'h00); PLAYER2 = 1'b1;
        hs_pulse(); read_y(y); chk("down_wrap_ff", y, 8'hFF);
        PLAYER2 = 1'b0;

        // Load beats coincident count; VBLANK holds; long low = one count
        VSLDn = 1'b0; BD = 8'h10; HSYNCn = 1'b0; step();
        VSLDn = 1'b1; HSYNCn = 1'b1; step();
        read_y(y); chk("load_prio", y, 8'h10);
        VBLANK = 1'b1;
        for (int i = 0; i < 5; i++) hs_pulse();
        read_y(y); chk("vblank_hold", y, 8'h10);
        VBLANK = 1'b0;
        HSYNCn = 1'b0;
        for (int i = 0; i < 6; i++) step();
        HSYNCn = 1'b1; step();
        read_y(y); chk("long_low_1cnt", y, 8'h11);

        // Slot mux sweep on the pin-select instance
        load_y(8'hB7); HL = 8'hC8; DRBA = 14'h152D;
        for (int i = 0; i < 4; i++) begin
            {SEL_B, SEL_A} = tbl[i].sel;
            step();
            chk($sformatf("mux_drab_sel%0d", i), drab_e, tbl[i].exp_drab);
            chk($sformatf("mux_slot_sel%0d", i), {6'd0, slot_e}, {6'd0, tbl[i].sel});
        end

        // Internal phase: realign, run 0..3,0, hs_fall at phase 2, then hold
        VBLANK = 1'b1;
        hs_pulse();
        PH_EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("phase_seq%0d", i), {6'd0, slot_i}, 8'(i % 4));
        end
        step();
        HSYNCn = 1'b0; step();
        chk("phase_at2", {6'd0, slot_i}, 8'd2);
        HSYNCn = 1'b1; PH_EN = 1'b0; step();
        chk("phase_fall_to0", {6'd0, slot_i}, 8'd0);
        step(); step();
        chk("phase_hold", {6'd0, slot_i}, 8'd0);
        VBLANK = 1'b0;

        // Mid-line reset with phase=3, Y=40
        PH_EN = 1'b1;
        load_y(8'h40); step(); step();
        PH_EN = 1'b0; step();
        chk("pre_rst_phase3", {6'd0, slot_i}, 8'd3);
        RESETn = 1'b0; PH_EN = 1'b1; HSYNCn = 1'b0; VSLDn = 1'b0; BD = 8'hAA;
        step();
        chk("mid_rst_drab_e", drab_e, 8'h00);
        chk("mid_rst_slot_i", {6'd0, slot_i}, 8'h00);
        chk("mid_rst_drab_i", drab_i, 8'h00);
        idle();
        step();
        chk("post_rst_phase0", {6'd0, slot_i}, 8'd0);
        read_y(y); chk("post_rst_y", y, 8'h00);

        // Randomised run against the model
        for (int i = 0; i < 3000; i++) begin
            RESETn  = ($urandom_range(0, 199) != 0);
            {SEL_B, SEL_A} = 2'($urandom);
            PH_EN   = 1'($urandom);
            PLAYER2 = 1'($urandom);
            HSYNCn  = ($urandom_range(0, 3) != 0);
            VBLANK  = ($urandom_range(0, 3) == 0);
            VSLDn   = ($urandom_range(0, 15) != 0);
            DRBA    = 14'($urandom);
            HL      = 8'($urandom);
            BD      = 8'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
